bus_arbiter_mux: RTL and testbench
==================================

BUS_ARBITER_MUX -- requirements
Module: bus_arbiter_mux

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  asynchronous active-low reset; reset==0 clears all state immediately.
REQ-002 For each master n=0..3, the block SHALL have these ports:
- mn_req_  in  1  bus request, active low.
- mn_as_  in  1  address strobe, active low.
- mn_addr  in  30  word address.
- mn_rw  in  1  READ=1 / WRITE=0.
- mn_wr_data  in  32  write data.
- mn_grnt_  out  1  grant, active low.
REQ-003 The shared bus side SHALL have these ports:
- s_as_  out  1  muxed strobe.
- s_addr  out  30  muxed address.
- s_rw  out  1  muxed direction.
- s_wr_data  out  32  muxed write data.
- s_rdy_  in  1  slave ready, active low.
- bus_rdy_  out  1  ready returned to all masters.
- owner  out  2  current owner index.
- timeout_err  out  1  one-cycle error pulse.

Function
REQ-004 A 2-bit owner register SHALL select the master; exactly one mn_grnt_ SHALL be low at all times, namely the one where n==owner (decoded combinationally).
REQ-005 At each clk edge, owner SHALL be updated as follows:
- If the current owner's req_ is low, owner is held.
- Otherwise owner becomes the first master with req_ low, searched circularly from owner+1 to owner+3 (mod 4).
- If no master is requesting, owner is held (bus parked).
REQ-006 A grant SHALL change exactly one cycle after the owner raises req_ high, provided another request is pending; the block SHALL NOT preempt while the owner holds req_ low.
REQ-007 s_as_, s_addr, s_rw and s_wr_data SHALL equal the owner's mn_as_, mn_addr, mn_rw and mn_wr_data, combinationally and with no added latency.
REQ-008 Non-owner strobes SHALL have no effect on s_as_.
REQ-009 A watchdog FSM SHALL have the states IDLE, WAIT and ERR.
REQ-010 Watchdog transitions SHALL be:
- IDLE->WAIT when s_as_==0; the 8-bit counter cnt clears to 0.
- WAIT->IDLE when s_rdy_==0.
- Otherwise WAIT increments cnt; when cnt==8'd255 with s_rdy_ still high, WAIT->ERR.
- ERR->IDLE unconditionally after one cycle.
REQ-011 bus_rdy_ SHALL be low when s_rdy_==0 OR state==ERR; otherwise bus_rdy_ SHALL be high.
REQ-012 timeout_err SHALL be high only in state ERR, giving exactly one cycle per timeout.
REQ-013 cnt SHALL saturate and never wrap; a slave ready arriving in the same cycle the limit is reached SHALL win, with WAIT->IDLE and no error.
REQ-014 If s_as_==0 and s_rdy_==0 in the same cycle while in IDLE, the watchdog SHALL remain in IDLE; the zero-wait access completes.
REQ-015 An owner change while the watchdog is in WAIT SHALL NOT reset cnt; the watchdog tracks the bus, not the master.

Reset
REQ-016 While reset==0, the block SHALL hold:
- owner=2'd0, so m0_grnt_=0 and m1..m3_grnt_=1.
- watchdog=IDLE, cnt=0, timeout_err=0.
- bus_rdy_ follows s_rdy_.
REQ-017 Deassertion of reset SHALL take effect at the next clk edge with no further initialisation cycles.
REQ-018 Reset asserted mid-transaction SHALL abort the watchdog immediately; any pending requests SHALL be re-arbitrated from owner 0.

Verification
REQ-019 Reset, no requests -> m0_grnt_=0, other grants=1, owner=0; all held for 20 cycles.
REQ-020 m2_req_ low with owner=0 idle -> one cycle later owner=2 and m2_grnt_=0; s_addr equals m2_addr (e.g. 30'h0000_1234).
REQ-021 m1, m2 and m3 all request; each releases req_ 3 cycles after grant -> grant order 1,2,3,1.
REQ-022 Owner m1 holds req_ low for 50 cycles while m0 requests -> owner stays 1 for the full 50 cycles, then switches to 0 one cycle after release.
REQ-023 s_as_ low, s_rdy_ held high -> after 256 WAIT cycles, one cycle with timeout_err=1 and bus_rdy_=0, then IDLE.
REQ-024 s_rdy_ low on the exact limit cycle -> no timeout_err; watchdog returns to IDLE.

Source files
------------

// File: rtl/bus_arbiter_mux.sv
// Four-master round-robin bus arbiter with a combinational bus mux and a
// watchdog that flags slaves which never return ready after a strobe.
module bus_arbiter_mux (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req_,
    input  logic        m0_as_,
    input  logic [29:0] m0_addr,
    input  logic        m0_rw,
    input  logic [31:0] m0_wr_data,
    output logic        m0_grnt_,
    input  logic        m1_req_,
    input  logic        m1_as_,
    input  logic [29:0] m1_addr,
    input  logic        m1_rw,
    input  logic [31:0] m1_wr_data,
    output logic        m1_grnt_,
    input  logic        m2_req_,
    input  logic        m2_as_,
    input  logic [29:0] m2_addr,
    input  logic        m2_rw,
    input  logic [31:0] m2_wr_data,
    output logic        m2_grnt_,
    input  logic        m3_req_,
    input  logic        m3_as_,
    input  logic [29:0] m3_addr,
    input  logic        m3_rw,
    input  logic [31:0] m3_wr_data,
    output logic        m3_grnt_,
    output logic        s_as_,
    output logic [29:0] s_addr,
    output logic        s_rw,
    output logic [31:0] s_wr_data,
    input  logic        s_rdy_,
    output logic        bus_rdy_,
    output logic [1:0]  owner,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        WD_IDLE = 2'd0,
        WD_WAIT = 2'd1,
        WD_ERR  = 2'd2
    } wd_state_t;

    logic [3:0]  w_req_n;
    logic [3:0]  w_as_n;
    logic [3:0]  w_rw;
    logic [3:0]  w_grnt_n;
    logic [29:0] w_addr    [4];
    logic [31:0] w_wr_data [4];
    logic [1:0]  w_owner_next;

    logic [1:0]  r_owner;
    wd_state_t   r_state;
    logic [7:0]  r_cnt;
    logic        r_timeout_err;

    assign w_req_n      = {m3_req_, m2_req_, m1_req_, m0_req_};
    assign w_as_n       = {m3_as_, m2_as_, m1_as_, m0_as_};
    assign w_rw         = {m3_rw, m2_rw, m1_rw, m0_rw};
    assign w_addr[0]    = m0_addr;
    assign w_addr[1]    = m1_addr;
    assign w_addr[2]    = m2_addr;
    assign w_addr[3]    = m3_addr;
    assign w_wr_data[0] = m0_wr_data;
    assign w_wr_data[1] = m1_wr_data;
    assign w_wr_data[2] = m2_wr_data;
    assign w_wr_data[3] = m3_wr_data;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_grant
            assign w_grnt_n[gi] = (r_owner != 2'(gi));
        end
    endgenerate

    assign m0_grnt_ = w_grnt_n[0];
    assign m1_grnt_ = w_grnt_n[1];
    assign m2_grnt_ = w_grnt_n[2];
    assign m3_grnt_ = w_grnt_n[3];

    // Scan farthest-first so the nearest requester after the owner wins.
    always_comb begin
        logic [1:0] v_cand;
        v_cand       = r_owner;
        w_owner_next = r_owner;
        if (w_req_n[r_owner]) begin
            for (int k = 3; k >= 1; k--) begin
                v_cand = r_owner + 2'(k);
                if (!w_req_n[v_cand]) begin
                    w_owner_next = v_cand;
                end
            end
        end
    end

    assign s_as_       = w_as_n[r_owner];
    assign s_addr      = w_addr[r_owner];
    assign s_rw        = w_rw[r_owner];
    assign s_wr_data   = w_wr_data[r_owner];
    assign owner       = r_owner;
    assign timeout_err = r_timeout_err;
    assign bus_rdy_    = s_rdy_ & ~r_timeout_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner       <= 2'd0;
            r_state       <= WD_IDLE;
            r_cnt         <= 8'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_owner       <= w_owner_next;
            r_timeout_err <= 1'b0;
            case (r_state)
                WD_IDLE: begin
                    // A zero-wait access (ready with the strobe) never arms the watchdog.
                    if (!s_as_ && s_rdy_) begin
                        r_state <= WD_WAIT;
                        r_cnt   <= 8'd0;
                    end
                end
                WD_WAIT: begin
                    if (!s_rdy_) begin
                        r_state <= WD_IDLE;
                    end else if (r_cnt == 8'd255) begin
                        r_state       <= WD_ERR;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                WD_ERR: begin
                    r_state <= WD_IDLE;
                end
                default: begin
                    r_state <= WD_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Randomised and directed stimulus for bus_arbiter_mux; expected outputs come
// from a behavioural model and are checked by a separate scoreboard monitor.
module tb_bus_arbiter_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic        m_req_ [4];
    logic        m_as_  [4];
    logic        m_rw   [4];
    logic [29:0] m_addr [4];
    logic [31:0] m_wd   [4];
    logic        m_grnt_[4];
    logic        s_rdy_;
    logic        s_as_, s_rw, bus_rdy_, timeout_err;
    logic [29:0] s_addr;
    logic [31:0] s_wr_data;
    logic [1:0]  owner;

    always #5 clk = ~clk;

    bus_arbiter_mux dut (
        .clk(clk), .reset(reset),
        .m0_req_(m_req_[0]), .m0_as_(m_as_[0]), .m0_addr(m_addr[0]), .m0_rw(m_rw[0]),
        .m0_wr_data(m_wd[0]), .m0_grnt_(m_grnt_[0]),
        .m1_req_(m_req_[1]), .m1_as_(m_as_[1]), .m1_addr(m_addr[1]), .m1_rw(m_rw[1]),
        .m1_wr_data(m_wd[1]), .m1_grnt_(m_grnt_[1]),
        .m2_req_(m_req_[2]), .m2_as_(m_as_[2]), .m2_addr(m_addr[2]), .m2_rw(m_rw[2]),
        .m2_wr_data(m_wd[2]), .m2_grnt_(m_grnt_[2]),
        .m3_req_(m_req_[3]), .m3_as_(m_as_[3]), .m3_addr(m_addr[3]), .m3_rw(m_rw[3]),
        .m3_wr_data(m_wd[3]), .m3_grnt_(m_grnt_[3]),
        .s_as_(s_as_), .s_addr(s_addr), .s_rw(s_rw), .s_wr_data(s_wr_data),
        .s_rdy_(s_rdy_), .bus_rdy_(bus_rdy_), .owner(owner), .timeout_err(timeout_err)
    );

    typedef struct packed {
        logic [1:0]  owner;
        logic [3:0]  grnt;
        logic        as_n;
        logic [29:0] addr;
        logic        rw;
        logic [31:0] wdata;
        logic        brdy;
        logic        terr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    // Reference model: owner index plus the watchdog as "waiting for N cycles".
    int   mdl_owner;
    bit   wd_waiting;
    bit   wd_err;
    int   wd_waited;
    int   held [4];
    int   off  [4];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, req);
        end
    endtask

    task automatic model_reset();
        mdl_owner  = 0;
        wd_waiting = 1'b0;
        wd_err     = 1'b0;
        wd_waited  = 0;
    endtask

    task automatic push_expect();
        exp_t e;
        if (!reset) model_reset();
        e.owner = 2'(mdl_owner);
        for (int n = 0; n < 4; n++) e.grnt[n] = (n != mdl_owner);
        e.as_n  = m_as_[mdl_owner];
        e.addr  = m_addr[mdl_owner];
        e.rw    = m_rw[mdl_owner];
        e.wdata = m_wd[mdl_owner];
        e.brdy  = s_rdy_ && !wd_err;
        e.terr  = wd_err;
        exp_q.push_back(e);
    endtask

    task automatic model_clock();
        logic bus_as_n;
        if (!reset) begin
            model_reset();
            return;
        end
        bus_as_n = m_as_[mdl_owner];
        if (wd_err) begin
            wd_err = 1'b0;
        end else if (wd_waiting) begin
            if (!s_rdy_) begin
                wd_waiting = 1'b0;
            end else if (wd_waited == 255) begin
                wd_waiting = 1'b0;
                wd_err     = 1'b1;
            end else begin
                wd_waited++;
            end
        end else if (!bus_as_n && s_rdy_) begin
            wd_waiting = 1'b1;
            wd_waited  = 0;
        end
        if (m_req_[mdl_owner]) begin
            for (int k = 1; k <= 3; k++) begin
                if (!m_req_[(mdl_owner + k) % 4]) begin
                    mdl_owner = (mdl_owner + k) % 4;
                    break;
                end
            end
        end
    endtask

    task automatic cycle();
        push_expect();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic idle_inputs();
        for (int n = 0; n < 4; n++) begin
            m_req_[n] = 1'b1;
            m_as_[n]  = 1'b1;
            m_rw[n]   = 1'($urandom);
            m_addr[n] = 30'($urandom);
            m_wd[n]   = $urandom;
        end
        s_rdy_ = 1'b1;
    endtask

    task automatic set_all_as(logic v);
        for (int n = 0; n < 4; n++) m_as_[n] = v;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("owner", 32'(owner), 32'(mon_e.owner));
                chk("grants", 32'({m_grnt_[3], m_grnt_[2], m_grnt_[1], m_grnt_[0]}), 32'(mon_e.grnt));
                chk("s_as_", 32'(s_as_), 32'(mon_e.as_n));
                chk("s_addr", 32'(s_addr), 32'(mon_e.addr));
                chk("s_rw", 32'(s_rw), 32'(mon_e.rw));
                chk("s_wr_data", s_wr_data, mon_e.wdata);
                chk("bus_rdy_", 32'(bus_rdy_), 32'(mon_e.brdy));
                chk("timeout_err", 32'(timeout_err), 32'(mon_e.terr));
            end
        end
    end

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk);
        #1;
        // Reset held with requests pending and a strobe active.
        for (int i = 0; i < 3; i++) begin
            for (int n = 0; n < 4; n++) m_req_[n] = 1'($urandom);
            m_as_[0] = 1'b0;
            s_rdy_   = 1'($urandom);
            cycle();
        end
        reset = 1'b1;
        idle_inputs();
        repeat (20) cycle();

        // Single request from master 2 while parked on 0.
        m_req_[2] = 1'b0;
        m_addr[2] = 30'h0000_1234;
        repeat (3) cycle();
        m_req_[2] = 1'b1;
        cycle();

        // Masters 1..3 contend, each releasing 3 cycles after its grant.
        for (int n = 0; n < 4; n++) begin
            held[n] = 0;
            off[n]  = 0;
        end
        for (int n = 1; n < 4; n++) m_req_[n] = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            for (int n = 1; n < 4; n++) begin
                if (!m_req_[n] && mdl_owner == n) begin
                    held[n]++;
                    if (held[n] >= 3) begin
                        m_req_[n] = 1'b1;
                        held[n]   = 0;
                        off[n]    = 2;
                    end
                end else if (m_req_[n] && off[n] > 0) begin
                    off[n]--;
                    if (off[n] == 0) m_req_[n] = 1'b0;
                end
            end
        end
        idle_inputs();
        repeat (3) cycle();

        // Owner 1 holds the bus for 50 cycles while master 0 waits.
        m_req_[1] = 1'b0;
        cycle();
        m_req_[0] = 1'b0;
        repeat (50) cycle();
        m_req_[1] = 1'b1;
        repeat (3) cycle();
        idle_inputs();
        cycle();

        // Watchdog timeout with the slave never responding.
        set_all_as(1'b0);
        repeat (262) cycle();
        set_all_as(1'b1);
        repeat (3) cycle();

        // Slave ready lands on the limit cycle.
        set_all_as(1'b0);
        cycle();
        repeat (255) cycle();
        s_rdy_ = 1'b0;
        cycle();
        s_rdy_ = 1'b1;
        set_all_as(1'b1);
        repeat (3) cycle();

        // Zero-wait access in IDLE.
        set_all_as(1'b0);
        s_rdy_ = 1'b0;
        repeat (4) cycle();
        set_all_as(1'b1);
        s_rdy_ = 1'b1;
        cycle();

        // Owner changes mid-wait, then reset aborts the transaction.
        set_all_as(1'b0);
        m_req_[3] = 1'b0;
        repeat (10) cycle();
        m_req_[3] = 1'b1;
        m_req_[1] = 1'b0;
        repeat (20) cycle();
        reset = 1'b0;
        repeat (2) cycle();
        reset = 1'b1;
        repeat (5) cycle();
        idle_inputs();
        cycle();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            for (int n = 0; n < 4; n++) begin
                if ($urandom_range(3) == 0) m_req_[n] = 1'($urandom);
                m_as_[n]  = ($urandom_range(2) != 0);
                m_rw[n]   = 1'($urandom);
                m_addr[n] = 30'($urandom);
                m_wd[n]   = $urandom;
            end
            s_rdy_ = ($urandom_range(7) != 0);
            reset  = ($urandom_range(499) != 0);
            cycle();
        end
        reset = 1'b1;
        idle_inputs();
        cycle();

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
